gpio_port: RTL and testbench
============================

Name: gpio_port

Overview:
Parametrised general-purpose I/O port, the next generation of the 8-bit write-only output latch. It adds:
- configurable width;
- per-bit output enable (direction);
- atomic set/clear/toggle writes;
- synchronised input readback;
- rising-edge capture with a maskable interrupt.

It sits on the CPU data bus as a memory-mapped peripheral. The address decoder drives WE and ADDR.

Parameters:
WIDTH, 8, number of I/O bits (legal range 1..32).
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (legal range 2..4).

Ports:
CLK  input  1  system clock; all state updates on the rising edge
RESET  input  1  asynchronous, active-high reset
WE  input  1  write strobe, one write per cycle when high
ADDR  input  3  register select
DATA_IN  input  32  write data; only bits [WIDTH-1:0] are used, upper bits ignored
DATA_OUT  output  32  read data, combinational from ADDR; bits [31:WIDTH] are 0
IO_IN  input  WIDTH  asynchronous pin inputs
IO_OUT  output  WIDTH  output data register
IO_OE  output  WIDTH  output enable per bit (1 = drive)
IRQ  output  1  interrupt request, OR of (IFLAG & IE)

Behaviour:
- Register map, selected by ADDR:
  - 0 OUT: read/write; write replaces the whole value.
  - 1 SET: OUT <= OUT | d; reads return OUT.
  - 2 CLR: OUT <= OUT & ~d; reads return OUT.
  - 3 TGL: OUT <= OUT ^ d; reads return OUT.
  - 4 DIR: read/write; drives IO_OE.
  - 5 IN: read-only; synchronised pin value; writes ignored.
  - 6 IE: read/write; per-bit interrupt enable.
  - 7 IFLAG: read / write-1-to-clear; rising-edge pending flags.
- d = DATA_IN[WIDTH-1:0]. A write takes effect at the CLK edge where WE=1.
- A written value is visible on IO_OUT / IO_OE / DATA_OUT in the following cycle.
- Reset (asynchronous, while RESET=1):
  - OUT, DIR, IE, IFLAG, synchroniser stages and edge-history register all go to 0.
  - Hence IO_OUT=0, IO_OE=0 (all inputs) and IRQ=0.
  - Reset asserted mid-operation clears everything immediately, with no clock needed.
- Input path:
  - IO_IN passes through a SYNC_STAGES-deep chain: s[0] <= IO_IN, s[k] <= s[k-1].
  - IN = s[SYNC_STAGES-1]. A pin change sampled at edge n is readable after edge n+SYNC_STAGES-1.
  - The history register prev <= IN every cycle.
  - rise = IN & ~prev. Each set bit of rise sets the matching IFLAG bit at the next edge.
  - Total latency from pin change to flag is SYNC_STAGES+1 edges.
  - Flags set regardless of IE and regardless of DIR; an output bit that is being driven still reads back through IN.
- IFLAG clear: a write to address 7 clears each IFLAG bit where d=1.
  - If a new rise and a clear hit the same bit in the same cycle, the set wins and the flag stays 1.
  - Other bits are unaffected.
- IRQ = |(IFLAG & IE), combinational from flops, so it is glitch-free relative to register outputs.
  - Enabling IE on a bit that is already pending asserts IRQ in the cycle after the write.
- Pins held high through reset produce a rising-edge flag SYNC_STAGES+1 cycles after release. This is defined behaviour; software clears IFLAG during init.
- WE=0: no state change except synchroniser, prev and IFLAG set logic.
- No read side effects. DATA_OUT decodes continuously.

Decomposition:
- Shared package gpio_pkg holds:
  - localparam address constants GPIO_OUT=0, GPIO_SET=1, GPIO_CLR=2, GPIO_TGL=3, GPIO_DIR=4, GPIO_IN=5, GPIO_IE=6, GPIO_IFLAG=7;
  - GPIO_MAX_WIDTH=32.
- One sub-module, sync_edge: the parametrised WIDTH × SYNC_STAGES synchroniser plus prev register. It outputs IN and rise, and is reusable by the future timer-capture block.
- Register file and read mux stay in gpio_port.

Test Plan:
- Reset: hold RESET=1 mid-run after writing OUT=8'hFF, DIR=8'hFF, with no CLK -> IO_OUT=0, IO_OE=0, IRQ=0 immediately, and all reads return 0.
- Atomic ops, WIDTH=8: write OUT=8'hA5, then SET 8'h0F, CLR 8'h81, TGL 8'hFF -> reads 8'hA5, 8'hAF, 8'h2E, 8'hD1 each one cycle later. DATA_IN[31:8]=all ones has no effect and DATA_OUT[31:8]=0.
- Input sync, SYNC_STAGES=2: IO_IN bit3 goes 0->1 before edge n -> IN bit3 reads 1 after edge n+1; IFLAG bit3=1 after edge n+2; IRQ stays 0 while IE=0.
- Interrupt: with IFLAG=8'h08, write IE=8'h08 -> IRQ=1 next cycle. Write IFLAG=8'h08 -> IRQ=0 next cycle.
- Race: a rise on bit0 lands in the same cycle as an IFLAG write of 8'h01 -> IFLAG bit0 remains 1 and IRQ stays asserted if enabled. A falling edge never sets a flag.
- WIDTH=32, SYNC_STAGES=3: OUT write of 32'hDEADBEEF reads back exactly. A pin rise gives a flag after 4 edges.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port: register map addresses and width limit.
package gpio_pkg;

    localparam logic [2:0] GPIO_OUT   = 3'd0;
    localparam logic [2:0] GPIO_SET   = 3'd1;
    localparam logic [2:0] GPIO_CLR   = 3'd2;
    localparam logic [2:0] GPIO_TGL   = 3'd3;
    localparam logic [2:0] GPIO_DIR   = 3'd4;
    localparam logic [2:0] GPIO_IN    = 3'd5;
    localparam logic [2:0] GPIO_IE    = 3'd6;
    localparam logic [2:0] GPIO_IFLAG = 3'd7;

    localparam int GPIO_MAX_WIDTH = 32;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage input synchroniser with a one-cycle history register.
// Produces the synchronised value and a one-cycle rising-edge pulse per bit.
module sync_edge #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] in_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
            prev_q <= stage_q[STAGES-1];
        end
    end

    assign in_o   = stage_q[STAGES-1];
    assign rise_o = stage_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: output latch with atomic set/clear/toggle,
// per-bit direction, synchronised readback and rising-edge interrupts.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WE,
    input  logic [2:0]       ADDR,
    input  logic [31:0]      DATA_IN,
    output logic [31:0]      DATA_OUT,
    input  logic [WIDTH-1:0] IO_IN,
    output logic [WIDTH-1:0] IO_OUT,
    output logic [WIDTH-1:0] IO_OE,
    output logic             IRQ
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] iflag_q, iflag_d;
    logic [WIDTH-1:0] syncIn;
    logic [WIDTH-1:0] riseVec;
    logic [WIDTH-1:0] wrData;
    logic [WIDTH-1:0] rdData;
    logic             unusedData;

    assign wrData     = DATA_IN[WIDTH-1:0];
    assign unusedData = ^(DATA_IN >> WIDTH);

    sync_edge #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (CLK),
        .rst    (RESET),
        .d_i    (IO_IN),
        .in_o   (syncIn),
        .rise_o (riseVec)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_q   <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            iflag_q <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            ie_q    <= ie_d;
            iflag_q <= iflag_d;
        end
    end

    // Edge sets are applied after the write-1-to-clear so a coincident rise keeps its flag.
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        ie_d    = ie_q;
        iflag_d = iflag_q;
        if (WE) begin
            case (ADDR)
                GPIO_OUT:   out_d   = wrData;
                GPIO_SET:   out_d   = out_q | wrData;
                GPIO_CLR:   out_d   = out_q & ~wrData;
                GPIO_TGL:   out_d   = out_q ^ wrData;
                GPIO_DIR:   dir_d   = wrData;
                GPIO_IE:    ie_d    = wrData;
                GPIO_IFLAG: iflag_d = iflag_q & ~wrData;
                default:    ;
            endcase
        end
        iflag_d = iflag_d | riseVec;
    end

    always_comb begin
        rdData = '0;
        case (ADDR)
            GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL: rdData = out_q;
            GPIO_DIR:   rdData = dir_q;
            GPIO_IN:    rdData = syncIn;
            GPIO_IE:    rdData = ie_q;
            GPIO_IFLAG: rdData = iflag_q;
            default:    rdData = '0;
        endcase
    end

    assign DATA_OUT = 32'(rdData);
    assign IO_OUT   = out_q;
    assign IO_OE    = dir_q;
    assign IRQ      = |(iflag_q & ie_q);

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: an 8-bit/2-stage instance and a 32-bit/3-stage instance.
`timescale 1ns/1ps
module tb_gpio_port;

    logic        clock;
    logic        reset;

    logic        we8;
    logic [2:0]  addr8;
    logic [31:0] dataIn8;
    logic [31:0] dataOut8;
    logic [7:0]  ioIn8;
    logic [7:0]  ioOut8;
    logic [7:0]  ioOe8;
    logic        irq8;

    logic        we32;
    logic [2:0]  addr32;
    logic [31:0] dataIn32;
    logic [31:0] dataOut32;
    logic [31:0] ioIn32;
    logic [31:0] ioOut32;
    logic [31:0] ioOe32;
    logic        irq32;

    int checks;
    int errors;

    gpio_port #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .CLK      (clock),
        .RESET    (reset),
        .WE       (we8),
        .ADDR     (addr8),
        .DATA_IN  (dataIn8),
        .DATA_OUT (dataOut8),
        .IO_IN    (ioIn8),
        .IO_OUT   (ioOut8),
        .IO_OE    (ioOe8),
        .IRQ      (irq8)
    );

    gpio_port #(.WIDTH(32), .SYNC_STAGES(3)) dut32 (
        .CLK      (clock),
        .RESET    (reset),
        .WE       (we32),
        .ADDR     (addr32),
        .DATA_IN  (dataIn32),
        .DATA_OUT (dataOut32),
        .IO_IN    (ioIn32),
        .IO_OUT   (ioOut32),
        .IO_OE    (ioOe32),
        .IRQ      (irq32)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] expRd;
        logic [7:0]  expOut;
        logic [7:0]  expOe;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
        we8     = 1'b1;
        addr8   = a;
        dataIn8 = d;
        tick();
        we8     = 1'b0;
    endtask

    task automatic write32(input logic [2:0] a, input logic [31:0] d);
        we32     = 1'b1;
        addr32   = a;
        dataIn32 = d;
        tick();
        we32     = 1'b0;
    endtask

    task automatic read8(input logic [2:0] a, output logic [31:0] v);
        we8   = 1'b0;
        addr8 = a;
        #0.2;
        v = dataOut8;
    endtask

    task automatic read32(input logic [2:0] a, output logic [31:0] v);
        we32   = 1'b0;
        addr32 = a;
        #0.2;
        v = dataOut32;
    endtask

    initial begin
        logic [31:0] rv;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        we8      = 1'b0;
        addr8    = 3'd0;
        dataIn8  = '0;
        ioIn8    = '0;
        we32     = 1'b0;
        addr32   = 3'd0;
        dataIn32 = '0;
        ioIn32   = '0;

        // Atomic-op table; upper DATA_IN bits are all ones and must be ignored.
        vecs[0] = '{1'b1, 3'd0, 32'hFFFF_FFA5, 3'd0, 32'h0000_00A5, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 3'd1, 32'hFFFF_FF0F, 3'd1, 32'h0000_00AF, 8'hAF, 8'h00};
        vecs[2] = '{1'b1, 3'd2, 32'hFFFF_FF81, 3'd2, 32'h0000_002E, 8'h2E, 8'h00};
        vecs[3] = '{1'b1, 3'd3, 32'hFFFF_FFFF, 3'd3, 32'h0000_00D1, 8'hD1, 8'h00};
        vecs[4] = '{1'b1, 3'd4, 32'hFFFF_FF3C, 3'd4, 32'h0000_003C, 8'hD1, 8'h3C};
        vecs[5] = '{1'b1, 3'd5, 32'hFFFF_FFFF, 3'd5, 32'h0000_0000, 8'hD1, 8'h3C};
        vecs[6] = '{1'b1, 3'd6, 32'hFFFF_FF00, 3'd6, 32'h0000_0000, 8'hD1, 8'h3C};
        vecs[7] = '{1'b0, 3'd0, 32'h0000_0000, 3'd1, 32'h0000_00D1, 8'hD1, 8'h3C};
        vecs[8] = '{1'b0, 3'd0, 32'h0000_0000, 3'd7, 32'h0000_0000, 8'hD1, 8'h3C};

        #3;
        checkOutput("reset IO_OUT", {24'h0, ioOut8}, 32'h0);
        checkOutput("reset IO_OE", {24'h0, ioOe8}, 32'h0);
        checkOutput("reset IRQ", {31'h0, irq8}, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].we) applyStimulus(vecs[i].addr, vecs[i].wdata);
            read8(vecs[i].raddr, rv);
            checkOutput($sformatf("vec%0d DATA_OUT", i), rv, vecs[i].expRd);
            checkOutput($sformatf("vec%0d IO_OUT", i), {24'h0, ioOut8}, {24'h0, vecs[i].expOut});
            checkOutput($sformatf("vec%0d IO_OE", i), {24'h0, ioOe8}, {24'h0, vecs[i].expOe});
        end

        // Pin bit3 rises before edge n: IN after n+1, flag after n+2.
        ioIn8[3] = 1'b1;
        tick();
        read8(3'd5, rv);
        checkOutput("sync IN after n", rv, 32'h00);
        tick();
        read8(3'd5, rv);
        checkOutput("sync IN after n+1", rv, 32'h08);
        read8(3'd7, rv);
        checkOutput("sync IFLAG after n+1", rv, 32'h00);
        tick();
        read8(3'd7, rv);
        checkOutput("sync IFLAG after n+2", rv, 32'h08);
        checkOutput("sync IRQ with IE=0", {31'h0, irq8}, 32'h0);

        applyStimulus(3'd6, 32'h08);
        checkOutput("IE enables pending IRQ", {31'h0, irq8}, 32'h1);
        applyStimulus(3'd7, 32'h08);
        checkOutput("IFLAG clear drops IRQ", {31'h0, irq8}, 32'h0);
        read8(3'd7, rv);
        checkOutput("IFLAG after clear", rv, 32'h00);

        // Bit0: first rise, then fall (no new flag), then rise racing a clear.
        applyStimulus(3'd6, 32'h01);
        ioIn8[0] = 1'b1;
        tick();
        tick();
        tick();
        read8(3'd7, rv);
        checkOutput("bit0 first rise flag", rv, 32'h01);
        checkOutput("bit0 first rise IRQ", {31'h0, irq8}, 32'h1);
        ioIn8[0] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        read8(3'd7, rv);
        checkOutput("bit0 fall keeps flag", rv, 32'h01);
        ioIn8[0] = 1'b1;
        tick();
        tick();
        applyStimulus(3'd7, 32'h01);
        read8(3'd7, rv);
        checkOutput("race set wins", rv, 32'h01);
        checkOutput("race IRQ held", {31'h0, irq8}, 32'h1);
        applyStimulus(3'd7, 32'h01);
        read8(3'd7, rv);
        checkOutput("clear after race", rv, 32'h00);
        ioIn8[0] = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        read8(3'd7, rv);
        checkOutput("falling edge no flag", rv, 32'h00);
        checkOutput("falling edge no IRQ", {31'h0, irq8}, 32'h0);

        // Wide instance: full 32-bit readback and a 4-edge flag latency.
        write32(3'd0, 32'hDEAD_BEEF);
        read32(3'd0, rv);
        checkOutput("w32 OUT readback", rv, 32'hDEAD_BEEF);
        checkOutput("w32 IO_OUT", ioOut32, 32'hDEAD_BEEF);
        ioIn32[31] = 1'b1;
        tick();
        tick();
        tick();
        read32(3'd7, rv);
        checkOutput("w32 IFLAG after 3 edges", rv, 32'h0);
        tick();
        read32(3'd7, rv);
        checkOutput("w32 IFLAG after 4 edges", rv, 32'h8000_0000);

        // Asynchronous reset mid-run, then a pin held high through reset.
        applyStimulus(3'd0, 32'hFF);
        applyStimulus(3'd4, 32'hFF);
        applyStimulus(3'd6, 32'hFF);
        checkOutput("pre-reset IO_OUT", {24'h0, ioOut8}, 32'hFF);
        #2;
        reset = 1'b1;
        #0.5;
        checkOutput("async reset IO_OUT", {24'h0, ioOut8}, 32'h0);
        checkOutput("async reset IO_OE", {24'h0, ioOe8}, 32'h0);
        checkOutput("async reset IRQ", {31'h0, irq8}, 32'h0);
        checkOutput("async reset w32 IO_OUT", ioOut32, 32'h0);
        for (int a = 0; a < 8; a++) begin
            read8(3'(a), rv);
            checkOutput($sformatf("reset read addr%0d", a), rv, 32'h0);
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        read8(3'd7, rv);
        checkOutput("post-reset IFLAG early", rv, 32'h00);
        tick();
        read8(3'd7, rv);
        checkOutput("post-reset held pin flag", rv, 32'h08);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
